// File: rtl/dc_axi_pkg.sv
// Shared types for the AXI4 read responder: burst and response encodings,
// the captured AR request record and the sequencing FSM states.
package dc_axi_pkg;

    localparam int PKG_ADDR_W = 32;
    localparam int PKG_ID_W   = 8;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [PKG_ID_W-1:0]   id;
        logic [PKG_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        burst_e                burst;
    } ar_req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2
    } state_e;

    // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
    function automatic logic wrap_len_ok(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/dc_axi_read_responder_skid.sv
// Two-entry valid/ready skid buffer on the R channel. When empty the input
// falls straight through to the output, so a beat costs no extra cycle; a
// beat that is not taken is parked and presented unchanged until accepted.
// The producer must not offer a beat when both entries are occupied; the
// occupancy count is exported so it can throttle itself.
module dc_axi_r_skid
    import dc_axi_pkg::*;
#(
    parameter int W = 27
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic [1:0]   count
);

    logic [W-1:0] ent0;
    logic [W-1:0] ent1;
    logic [1:0]   cnt;
    logic         fire;

    assign count     = cnt;
    assign out_valid = (cnt != 2'd0) || in_valid;
    assign fire      = out_valid && out_ready;

    // Head entry when occupied, else the incoming beat, else zero.
    always_comb begin
        out_data = '0;
        if (cnt != 2'd0) begin
            out_data = ent0;
        end else if (in_valid) begin
            out_data = in_data;
        end
    end

    // Occupancy and entry shifting.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (in_valid && !out_ready) begin
                        ent0 <= in_data;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (fire) begin
                        if (in_valid) begin
                            ent0 <= in_data;
                        end else begin
                            cnt <= 2'd0;
                        end
                    end else if (in_valid) begin
                        ent1 <= in_data;
                        cnt  <= 2'd2;
                    end
                end
                default: begin
                    if (fire) begin
                        ent0 <= ent1;
                        if (in_valid) begin
                            ent1 <= in_data;
                        end else begin
                            cnt <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/dc_axi_read_responder.sv
// AXI4 read-channel slave backed by on-chip frame memory with a preload
// write port. Serves FIXED/INCR/WRAP bursts of 16-bit beats, flags illegal
// bursts with SLVERR and out-of-range beats with DECERR.
// Optional build macro: DC_AXI_RESP_RANDOM_STALL_EN inserts LFSR-driven
// bubbles on beat issue and masks arready, to exercise master gap tolerance.
//
// state     | meaning
// ST_IDLE   | no burst in service; leave as soon as a request is queued
// ST_LOAD   | pop queue head, issue beat 0 RAM read
// ST_STREAM | issue remaining beats, wait for the last beat handshake
module dc_axi_read_responder
    import dc_axi_pkg::*;
#(
    parameter int AXI_ARADDR_WIDTH = PKG_ADDR_W,
    parameter int AXI_ID_WIDTH     = PKG_ID_W,
    parameter int DATA_WIDTH       = 16,
    parameter int MEM_WORDS        = 16384,
    parameter int MEM_ADDR_WIDTH   = 15,
    parameter int ARQ_DEPTH        = 2
)(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic [MEM_ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    input  logic [AXI_ID_WIDTH-1:0]     axi_arid,
    input  logic [AXI_ARADDR_WIDTH-1:0] axi_araddr,
    input  logic [7:0]                  axi_arlen,
    input  logic [2:0]                  axi_arsize,
    input  logic [1:0]                  axi_arburst,
    input  logic [1:0]                  axi_arlock,
    input  logic [3:0]                  axi_arcache,
    input  logic [2:0]                  axi_arprot,
    input  logic [3:0]                  axi_arqos,
    input  logic [3:0]                  axi_arregion,
    input  logic                        axi_arvalid,
    output logic                        axi_arready,
    output logic [AXI_ID_WIDTH-1:0]     axi_rid,
    output logic [DATA_WIDTH-1:0]       axi_rdata,
    output logic [1:0]                  axi_rresp,
    output logic                        axi_rlast,
    output logic                        axi_rvalid,
    input  logic                        axi_rready,
    output logic                        busy
);

    localparam int WAW       = AXI_ARADDR_WIDTH - 1;
    localparam int RAM_IDX_W = $clog2(MEM_WORDS);
    localparam int QPW       = $clog2(ARQ_DEPTH);
    localparam int SKID_W    = AXI_ID_WIDTH + DATA_WIDTH + 3;

    state_e state;
    state_e state_nxt;

    ar_req_t        ar_in;
    ar_req_t        q_mem [ARQ_DEPTH];
    ar_req_t        q_head;
    logic [QPW-1:0] q_wr_ptr;
    logic [QPW-1:0] q_rd_ptr;
    logic [QPW:0]   q_cnt;
    logic           q_empty;
    logic           q_full;
    logic           ar_push;
    logic           q_pop;

    ar_req_t        cur_req;
    ar_req_t        src;
    logic [8:0]     issue_cnt;
    logic [7:0]     beat_idx;
    logic           all_issued;
    logic           burst_err;
    logic [WAW-1:0] w0;
    logic [WAW-1:0] beat_x;
    logic [WAW-1:0] len_x;
    logic [WAW-1:0] incr_w;
    logic [WAW-1:0] beat_w;
    logic           beat_oob;
    logic [1:0]     beat_resp;
    logic           issue;
    logic           stall_beat;
    logic           stall_ar;

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic [DATA_WIDTH-1:0] ram_q;
    logic                  wr_ok;

    logic                    s1_valid;
    logic [AXI_ID_WIDTH-1:0] s1_id;
    logic [1:0]              s1_resp;
    logic                    s1_last;
    logic [DATA_WIDTH-1:0]   s1_data;

    logic [SKID_W-1:0] r_bus;
    logic [1:0]        skid_cnt;
    logic [2:0]        skid_occ;
    logic              room;
    logic              r_fire;

`ifdef DC_AXI_RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;

    // Free-running Fibonacci LFSR, taps 16,14,13,11.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    assign stall_beat = (lfsr[1:0] == 2'b00);
    assign stall_ar   = (lfsr[3:2] == 2'b00);
`else
    assign stall_beat = 1'b0;
    assign stall_ar   = 1'b0;
`endif

    // ---------------- AR queue ----------------
    assign q_empty     = (q_cnt == '0);
    assign q_full      = (q_cnt == (QPW+1)'(ARQ_DEPTH));
    assign axi_arready = !rst && !q_full && !stall_ar;
    assign ar_push     = axi_arvalid && axi_arready;
    assign q_pop       = (state == ST_LOAD);
    assign q_head      = q_mem[q_rd_ptr];

    // Pack the AR channel into a request record.
    always_comb begin
        ar_in       = '0;
        ar_in.id    = axi_arid;
        ar_in.addr  = axi_araddr;
        ar_in.len   = axi_arlen;
        ar_in.size  = axi_arsize;
        ar_in.burst = burst_e'(axi_arburst);
    end

    // Queue storage, written on AR handshake.
    always_ff @(posedge clk) begin
        if (ar_push) begin
            q_mem[q_wr_ptr] <= ar_in;
        end
    end

    // Queue pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_wr_ptr <= '0;
            q_rd_ptr <= '0;
            q_cnt    <= '0;
        end else begin
            if (ar_push) begin
                q_wr_ptr <= q_wr_ptr + QPW'(1);
            end
            if (q_pop) begin
                q_rd_ptr <= q_rd_ptr + QPW'(1);
            end
            if (ar_push && !q_pop) begin
                q_cnt <= q_cnt + (QPW+1)'(1);
            end else if (!ar_push && q_pop) begin
                q_cnt <= q_cnt - (QPW+1)'(1);
            end
        end
    end

    // ---------------- Beat generation ----------------
    // In LOAD the head of the queue drives beat 0 directly so the first
    // RAM read is not delayed by the request register.
    always_comb begin
        src      = cur_req;
        beat_idx = issue_cnt[7:0];
        if (state == ST_LOAD) begin
            src      = q_head;
            beat_idx = 8'd0;
        end
    end

    assign burst_err = (src.size != 3'd1) || (src.burst == BURST_RSVD) ||
                       ((src.burst == BURST_WRAP) && !wrap_len_ok(src.len));

    // Odd byte addresses are aligned down by dropping bit 0.
    assign w0     = src.addr[AXI_ARADDR_WIDTH-1:1];
    assign beat_x = WAW'(beat_idx);
    assign len_x  = WAW'(src.len);
    assign incr_w = w0 + beat_x;

    // Word index of the current beat.
    always_comb begin
        beat_w = incr_w;
        case (src.burst)
            BURST_FIXED: beat_w = w0;
            BURST_WRAP:  beat_w = (w0 & ~len_x) | (incr_w & len_x);
            default:     beat_w = incr_w;
        endcase
    end

    assign beat_oob  = (beat_w >= WAW'(MEM_WORDS));
    assign beat_resp = burst_err ? RESP_SLVERR : (beat_oob ? RESP_DECERR : RESP_OKAY);

    // Issue only if the beat will have a slot in the skid buffer when it
    // lands next cycle, counting the beat leaving on this cycle's handshake.
    assign r_fire     = axi_rvalid && axi_rready;
    assign skid_occ   = {1'b0, skid_cnt} + {2'b00, s1_valid} - {2'b00, r_fire};
    assign room       = (skid_occ <= 3'd1);
    assign all_issued = (issue_cnt > {1'b0, cur_req.len});
    assign issue      = (state == ST_LOAD) ||
                        ((state == ST_STREAM) && !all_issued && room && !stall_beat);

    // ---------------- FSM ----------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state; an AR accepted while idle goes straight to LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!q_empty || ar_push) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
                if (r_fire && axi_rlast) begin
                    state_nxt = q_empty ? ST_IDLE : ST_LOAD;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Active request and issued-beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_req   <= '0;
            issue_cnt <= '0;
        end else if (state == ST_LOAD) begin
            cur_req   <= q_head;
            issue_cnt <= 9'd1;
        end else if (issue) begin
            issue_cnt <= issue_cnt + 9'd1;
        end
    end

    // ---------------- Frame memory ----------------
    assign wr_ok = wr_en && (32'(wr_addr) < 32'(MEM_WORDS));

    // Single-port-style RAM, read-first on a same-word collision.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[RAM_IDX_W-1:0]] <= wr_data;
        end
        if (issue) begin
            ram_q <= mem[beat_w[RAM_IDX_W-1:0]];
        end
    end

    // Beat metadata travels alongside the RAM read.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= issue;
        end
        if (issue) begin
            s1_id   <= src.id;
            s1_resp <= beat_resp;
            s1_last <= (beat_idx == src.len);
        end
    end

    assign s1_data = (s1_resp == RESP_OKAY) ? ram_q : '0;

    dc_axi_r_skid #(
        .W (SKID_W)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (s1_valid),
        .in_data   ({s1_id, s1_data, s1_resp, s1_last}),
        .out_valid (axi_rvalid),
        .out_data  (r_bus),
        .out_ready (axi_rready),
        .count     (skid_cnt)
    );

    assign {axi_rid, axi_rdata, axi_rresp, axi_rlast} = r_bus;
    assign busy = !q_empty || (state != ST_IDLE) || axi_rvalid;

    logic unused_sigs;
    assign unused_sigs = ^{axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                           axi_arregion, src.addr[0]};

endmodule

// File: tb/tb_dc_axi_read_responder.sv
// Directed bench for dc_axi_read_responder: INCR/WRAP/FIXED addressing,
// R backpressure, burst and decode errors, AR queue fill and reset abort.
module tb_dc_axi_read_responder;

    localparam int MEM_WORDS = 16384;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [15:0] wr_data;
    logic [7:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [7:0]  axi_rid;
    logic [15:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] bd [0:31];
    logic [1:0]  br [0:31];
    logic [7:0]  bi [0:31];
    logic        bl [0:31];
    int col_n;
    int col_first;
    int hold_bad;
    int hold_seen;

    dc_axi_read_responder dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .axi_arid     (axi_arid),
        .axi_araddr   (axi_araddr),
        .axi_arlen    (axi_arlen),
        .axi_arsize   (axi_arsize),
        .axi_arburst  (axi_arburst),
        .axi_arlock   (2'b00),
        .axi_arcache  (4'h0),
        .axi_arprot   (3'b000),
        .axi_arqos    (4'h0),
        .axi_arregion (4'h0),
        .axi_arvalid  (axi_arvalid),
        .axi_arready  (axi_arready),
        .axi_rid      (axi_rid),
        .axi_rdata    (axi_rdata),
        .axi_rresp    (axi_rresp),
        .axi_rlast    (axi_rlast),
        .axi_rvalid   (axi_rvalid),
        .axi_rready   (axi_rready),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Presents one AR and holds it until accepted; returns 1ns after the
    // handshake edge.
    task automatic send_ar(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        bit acc;
        axi_arid    = id;
        axi_araddr  = addr;
        axi_arlen   = len;
        axi_arsize  = size;
        axi_arburst = burst;
        axi_arvalid = 1'b1;
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (axi_arready === 1'b1) begin
                acc = 1;
                break;
            end
        end
        @(posedge clk); #1;
        axi_arvalid = 1'b0;
        checks++;
        if (!acc) begin
            failures++;
            $display("FAIL ar_accept id=%0h: arready stayed low, required 1", id);
        end
    endtask

    // Records accepted beats; optionally toggles rready every cycle and
    // tracks whether a stalled beat stayed unchanged. Returns at a negedge.
    task automatic collect(input int n, input bit toggle, input int budget);
        logic [15:0] hd;
        logic [7:0]  hi;
        logic [1:0]  hr;
        logic        hl;
        bit          pend;
        col_n = 0; col_first = -1; hold_bad = 0; hold_seen = 0; pend = 0;
        hd = '0; hi = '0; hr = '0; hl = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (pend) begin
                if (axi_rvalid !== 1'b1 || axi_rdata !== hd || axi_rid !== hi ||
                    axi_rresp !== hr || axi_rlast !== hl)
                    hold_bad++;
            end
            pend = 0;
            if (axi_rvalid === 1'b1 && col_first < 0) col_first = c;
            if (axi_rvalid === 1'b1 && axi_rready === 1'b1) begin
                if (col_n < 32) begin
                    bd[col_n] = axi_rdata;
                    br[col_n] = axi_rresp;
                    bi[col_n] = axi_rid;
                    bl[col_n] = axi_rlast;
                end
                col_n++;
            end else if (axi_rvalid === 1'b1) begin
                pend = 1; hold_seen++;
                hd = axi_rdata; hi = axi_rid; hr = axi_rresp; hl = axi_rlast;
            end
            if (col_n >= n) break;
            @(posedge clk); #1;
            if (toggle) axi_rready = ~axi_rready;
        end
    endtask

    task automatic preload();
        @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 15'(i); wr_data = 16'(i);
            @(posedge clk); #1;
        end
        wr_en = 1'b1; wr_addr = 15'(MEM_WORDS - 1); wr_data = 16'(MEM_WORDS - 1);
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0; axi_arsize = 3'd1;
        axi_arburst = 2'd1; axi_arvalid = 1'b0; axi_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (axi_arready !== 1'b0 || axi_rvalid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: arready=%b rvalid=%b busy=%b, required 0 0 0",
                     axi_arready, axi_rvalid, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (axi_arready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_arready: got %b, required 1", axi_arready);
        end
    endtask

    task automatic test_incr_basic();
        @(posedge clk); #1;
        axi_rready = 1'b1;
        send_ar(8'h05, 32'h0000, 8'd7, 3'd1, 2'd1);
        @(negedge clk);
        checks++;
        if (axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL incr_latency_early: rvalid=%b one cycle after AR, required 0", axi_rvalid);
        end
        collect(8, 1'b0, 40);
        checks++;
        if (col_first !== 0) begin
            failures++;
            $display("FAIL incr_latency: first rvalid at +%0d, required +0 (2 cycles after AR)", col_first);
        end
        checks++;
        if (col_n !== 8) begin
            failures++;
            $display("FAIL incr_beats: got %0d beats, required 8", col_n);
        end
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (bd[b] !== 16'(b) || br[b] !== 2'b00 || bi[b] !== 8'h05 || bl[b] !== (b == 7)) begin
                failures++;
                $display("FAIL incr_beat%0d: data=%0h resp=%0d id=%0h last=%b, required %0h 0 05 %b",
                         b, bd[b], br[b], bi[b], bl[b], b, (b == 7));
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL incr_busy_after: busy=%b, required 0", busy);
        end
    endtask

    task automatic test_rready_toggle();
        logic [15:0] exp_d [0:3];
        exp_d[0] = 16'd8; exp_d[1] = 16'd9; exp_d[2] = 16'd10; exp_d[3] = 16'd11;
        @(posedge clk); #1;
        axi_rready = 1'b1;
        send_ar(8'h09, 32'h0010, 8'd3, 3'd1, 2'd1);
        collect(4, 1'b1, 40);
        axi_rready = 1'b1;
        checks++;
        if (col_n !== 4) begin
            failures++;
            $display("FAIL toggle_beats: got %0d beats, required 4", col_n);
        end
        checks++;
        if (hold_seen == 0 || hold_bad != 0) begin
            failures++;
            $display("FAIL toggle_hold: stalled=%0d changed=%0d, required stalled>0 changed=0",
                     hold_seen, hold_bad);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (bd[b] !== exp_d[b] || br[b] !== 2'b00 || bl[b] !== (b == 3)) begin
                failures++;
                $display("FAIL toggle_beat%0d: data=%0d resp=%0d last=%b, required %0d 0 %b",
                         b, bd[b], br[b], bl[b], exp_d[b], (b == 3));
            end
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_d [0:3];
        exp_d[0] = 16'd6; exp_d[1] = 16'd7; exp_d[2] = 16'd4; exp_d[3] = 16'd5;
        @(posedge clk); #1;
        axi_rready = 1'b1;
        send_ar(8'h21, 32'h000C, 8'd3, 3'd1, 2'd2);
        collect(4, 1'b0, 40);
        checks++;
        if (col_n !== 4) begin
            failures++;
            $display("FAIL wrap4_beats: got %0d, required 4", col_n);
        end
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (bd[b] !== exp_d[b] || br[b] !== 2'b00 || bi[b] !== 8'h21 || bl[b] !== (b == 3)) begin
                failures++;
                $display("FAIL wrap4_beat%0d: data=%0d resp=%0d id=%0h last=%b, required %0d 0 21 %b",
                         b, bd[b], br[b], bi[b], bl[b], exp_d[b], (b == 3));
            end
        end
        @(posedge clk); #1;
        send_ar(8'h22, 32'h000C, 8'd2, 3'd1, 2'd2);
        collect(3, 1'b0, 40);
        checks++;
        if (col_n !== 3) begin
            failures++;
            $display("FAIL wrap3_beats: got %0d, required 3", col_n);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (bd[b] !== 16'd0 || br[b] !== 2'b10 || bl[b] !== (b == 2)) begin
                failures++;
                $display("FAIL wrap3_beat%0d: data=%0d resp=%0d last=%b, required 0 2 %b",
                         b, bd[b], br[b], bl[b], (b == 2));
            end
        end
    endtask

    task automatic test_errors();
        @(posedge clk); #1;
        axi_rready = 1'b1;
        send_ar(8'h31, 32'h0004, 8'd1, 3'd2, 2'd1);
        collect(2, 1'b0, 40);
        checks++;
        if (col_n !== 2) begin
            failures++;
            $display("FAIL size_err_beats: got %0d, required 2", col_n);
        end
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bd[b] !== 16'd0 || br[b] !== 2'b10 || bl[b] !== (b == 1)) begin
                failures++;
                $display("FAIL size_err_beat%0d: data=%0d resp=%0d last=%b, required 0 2 %b",
                         b, bd[b], br[b], bl[b], (b == 1));
            end
        end
        @(posedge clk); #1;
        send_ar(8'h32, 32'(2 * MEM_WORDS - 2), 8'd1, 3'd1, 2'd1);
        collect(2, 1'b0, 40);
        checks++;
        if (col_n !== 2) begin
            failures++;
            $display("FAIL decerr_beats: got %0d, required 2", col_n);
        end
        checks++;
        if (bd[0] !== 16'h3FFF || br[0] !== 2'b00 || bl[0] !== 1'b0) begin
            failures++;
            $display("FAIL decerr_beat0: data=%0h resp=%0d last=%b, required 3fff 0 0",
                     bd[0], br[0], bl[0]);
        end
        checks++;
        if (bd[1] !== 16'd0 || br[1] !== 2'b11 || bl[1] !== 1'b1 || bi[1] !== 8'h32) begin
            failures++;
            $display("FAIL decerr_beat1: data=%0h resp=%0d last=%b id=%0h, required 0 3 1 32",
                     bd[1], br[1], bl[1], bi[1]);
        end
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        axi_rready = 1'b0;
        // The first request is popped into service, so two more fill the queue.
        send_ar(8'h01, 32'h0000, 8'd0, 3'd1, 2'd1);
        send_ar(8'h02, 32'h0002, 8'd0, 3'd1, 2'd1);
        send_ar(8'h03, 32'h0004, 8'd0, 3'd1, 2'd1);
        @(negedge clk);
        checks++;
        if (axi_arready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_full_arready: got %b, required 0", axi_arready);
        end
        checks++;
        if (axi_rvalid !== 1'b1 || axi_rid !== 8'h01 || busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stalled_head: rvalid=%b rid=%0h busy=%b, required 1 01 1",
                     axi_rvalid, axi_rid, busy);
        end
        @(posedge clk); #1;
        axi_rready = 1'b1;
        collect(3, 1'b0, 60);
        checks++;
        if (col_n !== 3) begin
            failures++;
            $display("FAIL b2b_beats: got %0d, required 3", col_n);
        end
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (bi[b] !== 8'(b + 1) || bd[b] !== 16'(b) || bl[b] !== 1'b1 || br[b] !== 2'b00) begin
                failures++;
                $display("FAIL b2b_beat%0d: id=%0h data=%0d last=%b resp=%0d, required %0h %0d 1 0",
                         b, bi[b], bd[b], bl[b], br[b], b + 1, b);
            end
        end
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (axi_arready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: arready=%b busy=%b, required 1 0", axi_arready, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int stray;
        @(posedge clk); #1;
        axi_rready = 1'b1;
        send_ar(8'h07, 32'h0000, 8'd15, 3'd1, 2'd1);
        collect(3, 1'b0, 40);
        checks++;
        if (col_n !== 3) begin
            failures++;
            $display("FAIL abort_pre_beats: got %0d, required 3", col_n);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (axi_rvalid !== 1'b0 || axi_arready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_state: rvalid=%b arready=%b busy=%b, required 0 0 0",
                     axi_rvalid, axi_arready, busy);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (axi_rvalid === 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL abort_stray_beats: saw %0d rvalid cycles, required 0", stray);
        end
        @(posedge clk); #1;
        send_ar(8'h08, 32'h0020, 8'd1, 3'd1, 2'd1);
        collect(2, 1'b0, 40);
        checks++;
        if (col_n !== 2) begin
            failures++;
            $display("FAIL post_reset_beats: got %0d, required 2", col_n);
        end
        for (int b = 0; b < 2; b++) begin
            checks++;
            if (bd[b] !== 16'(16 + b) || bi[b] !== 8'h08 || br[b] !== 2'b00 || bl[b] !== (b == 1)) begin
                failures++;
                $display("FAIL post_reset_beat%0d: data=%0d id=%0h resp=%0d last=%b, required %0d 08 0 %b",
                         b, bd[b], bi[b], br[b], bl[b], 16 + b, (b == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_incr_basic();
        test_rready_toggle();
        test_wrap();
        test_errors();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
